instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader_pkg.sv | 14 +
 rtl/instruction_loader_byte_assembler.sv | 41 ++++
 rtl/instruction_loader.sv | 123 ++++++++++++
 tb/tb_instruction_loader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// Shared constants and FSM encoding for the instruction loader.
package instruction_loader_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReceive = 2'd1,
    StWrite   = 2'd2,
    StDone    = 2'd3
  } state_e;

  localparam logic [31:0] HaltWordDefault = 32'hFFFF_FFFF;
  localparam int unsigned BytesPerWord    = 4;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// Shifts received bytes into a word, MSB first, and flags the final byte of each word.
module instruction_loader_byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_shift_en,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_ready
);

  localparam int unsigned     NbIdx   = $clog2(BytesPerWord);
  localparam logic [NbIdx-1:0] LastIdx = NbIdx'(BytesPerWord - 1);

  logic [NbIdx-1:0]   r_idx;
  logic [NB_DATA-1:0] r_word;

  // Shift register and byte index; clear discards any partial word.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_shift_en) begin
      r_word <= {r_word[NB_DATA-NB_BYTE-1:0], i_byte};
      r_idx  <= (r_idx == LastIdx) ? '0 : r_idx + NbIdx'(1);
    end
  end

  // Word completes on the edge that accepts this byte.
  assign o_word_ready = i_shift_en && (r_idx == LastIdx);
  assign o_word       = r_word;

endmodule

// File: rtl/instruction_loader.sv
// Loads a program from a byte stream into instruction memory, stalling the CPU meanwhile.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned        NB_DATA   = 32,
  parameter int unsigned        NB_BYTE   = 8,
  parameter int unsigned        NB_ADDR   = 10,
  parameter logic [NB_DATA-1:0] HALT_WORD = HaltWordDefault
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_load_start,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic               o_imem_wr_en,
  output logic [NB_ADDR-1:0] o_imem_addr,
  output logic [NB_DATA-1:0] o_imem_data,
  output logic               o_cpu_stall,
  output logic               o_load_done,
  output logic               o_overflow,
  output logic [NB_ADDR:0]   o_word_count
);

  localparam logic [NB_ADDR-1:0] LastAddr = '1;

  state_e             r_state;
  state_e             w_next_state;
  logic               w_clear;
  logic               w_shift_en;
  logic               w_write;
  logic               w_word_ready;
  logic               w_is_halt;
  logic [NB_DATA-1:0] w_word;
  logic [NB_ADDR-1:0] r_addr;
  logic [NB_ADDR:0]   r_count;
  logic               r_overflow;
  logic [NB_ADDR-1:0] r_last_addr;
  logic [NB_DATA-1:0] r_last_data;

  instruction_loader_byte_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_byte_assembler (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (w_clear),
    .i_shift_en   (w_shift_en),
    .i_byte       (i_rx_data),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  assign w_write   = (r_state == StWrite);
  assign w_is_halt = (w_word == HALT_WORD);

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus assembler control; bytes are only accepted in StReceive.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift_en   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_load_start) begin
          w_clear      = 1'b1;
          w_next_state = StReceive;
        end
      end
      StReceive: begin
        w_shift_en = i_rx_done;
        if (w_word_ready) w_next_state = StWrite;
      end
      StWrite: begin
        if (w_is_halt || (r_addr == LastAddr)) w_next_state = StDone;
        else                                   w_next_state = StReceive;
      end
      StDone:  w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  // Address, count, overflow and the held copy of the last write.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_addr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_last_addr <= '0;
      r_last_data <= '0;
    end else if (w_clear) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_write) begin
      r_count     <= r_count + (NB_ADDR + 1)'(1);
      r_last_addr <= r_addr;
      r_last_data <= w_word;
      // Overflow is checked before incrementing so the address never wraps.
      if (!w_is_halt) begin
        if (r_addr == LastAddr) r_overflow <= 1'b1;
        else                    r_addr     <= r_addr + NB_ADDR'(1);
      end
    end
  end

  // Memory bus shows live values during the write and holds them afterwards.
  assign o_imem_wr_en = w_write;
  assign o_imem_addr  = w_write ? r_addr : r_last_addr;
  assign o_imem_data  = w_write ? w_word : r_last_data;
  assign o_cpu_stall  = (r_state != StIdle);
  assign o_load_done  = (r_state == StDone);
  assign o_overflow   = r_overflow;
  assign o_word_count = r_count;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: a default-size instance and a 4-word instance.
module tb_instruction_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance (NB_ADDR = 10)
  logic        b_start, b_rx_done;
  logic [7:0]  b_rx_data;
  logic        b_wr_en, b_stall, b_done, b_ovf;
  logic [9:0]  b_addr;
  logic [31:0] b_data;
  logic [10:0] b_count;

  // Small instance (NB_ADDR = 2)
  logic        s_start, s_rx_done;
  logic [7:0]  s_rx_data;
  logic        s_wr_en, s_stall, s_done, s_ovf;
  logic [1:0]  s_addr;
  logic [31:0] s_data;
  logic [2:0]  s_count;

  instruction_loader dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_load_start (b_start),
    .i_rx_data    (b_rx_data),
    .i_rx_done    (b_rx_done),
    .o_imem_wr_en (b_wr_en),
    .o_imem_addr  (b_addr),
    .o_imem_data  (b_data),
    .o_cpu_stall  (b_stall),
    .o_load_done  (b_done),
    .o_overflow   (b_ovf),
    .o_word_count (b_count)
  );

  instruction_loader #(.NB_ADDR(2)) dut_small (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_load_start (s_start),
    .i_rx_data    (s_rx_data),
    .i_rx_done    (s_rx_done),
    .o_imem_wr_en (s_wr_en),
    .o_imem_addr  (s_addr),
    .o_imem_data  (s_data),
    .o_cpu_stall  (s_stall),
    .o_load_done  (s_done),
    .o_overflow   (s_ovf),
    .o_word_count (s_count)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [9:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [1:0]  sa_q[$];
  logic [31:0] sd_q[$];

  // Record every write strobe seen, mid-cycle.
  always @(negedge clk) begin
    if (b_wr_en) begin
      wa_q.push_back(b_addr);
      wd_q.push_back(b_data);
    end
    if (s_wr_en) begin
      sa_q.push_back(s_addr);
      sd_q.push_back(s_data);
    end
  end

  task automatic send(input bit sm, input logic [7:0] b, input int gap);
    if (sm) begin s_rx_data = b; s_rx_done = 1'b1; end
    else    begin b_rx_data = b; b_rx_done = 1'b1; end
    @(negedge clk);
    s_rx_done = 1'b0;
    b_rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Last word of a program uses no trailing gap so the done pulse is not skipped.
  task automatic send_word(input bit sm, input logic [31:0] w, input int gap, input bit last);
    for (int i = 0; i < 4; i++) begin
      send(sm, w[31-8*i -: 8], (last && i == 3) ? 0 : gap);
    end
  endtask

  task automatic pulse_start(input bit sm);
    if (sm) s_start = 1'b1; else b_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_done(input bit sm, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (sm ? s_done : b_done) seen = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({b_wr_en, b_stall, b_done, b_ovf} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 0000", {b_wr_en, b_stall, b_done, b_ovf});
    end
    vectors++;
    if (b_addr !== 10'd0 || b_data !== 32'd0 || b_count !== 11'd0) begin
      miscompares++;
      $display("FAIL reset_bus: got addr=%0h data=%0h count=%0d want 0", b_addr, b_data, b_count);
    end
    vectors++;
    if ({s_wr_en, s_stall, s_done, s_ovf} !== 4'b0 || s_count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_small: got flags=%b count=%0d want 0", {s_wr_en, s_stall, s_done, s_ovf},
               s_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit seen;
    wa_q.delete(); wd_q.delete();
    pulse_start(0);
    vectors++;
    if (b_stall !== 1'b1) begin
      miscompares++; $display("FAIL basic_stall_on: got %b want 1", b_stall);
    end
    send_word(0, 32'h2008_0005, 1, 0);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    wait_done(0, seen);
    vectors++;
    if (!seen || b_stall !== 1'b1) begin
      miscompares++; $display("FAIL basic_done: got done=%b stall=%b want 1 1", seen, b_stall);
    end
    @(negedge clk);
    vectors++;
    if (b_stall !== 1'b0 || b_done !== 1'b0 || b_count !== 11'd2 || b_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after: got stall=%b done=%b count=%0d ovf=%b want 0 0 2 0",
               b_stall, b_done, b_count, b_ovf);
    end
    vectors++;
    if (wa_q.size() != 2) begin
      miscompares++; $display("FAIL basic_nwrites: got %0d want 2", wa_q.size());
    end else if (wa_q[0] !== 10'd0 || wd_q[0] !== 32'h2008_0005 ||
                 wa_q[1] !== 10'd1 || wd_q[1] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL basic_writes: got %0h@%0d %0h@%0d want 20080005@0 ffffffff@1",
               wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
    end
    vectors++;
    if (b_addr !== 10'd1 || b_data !== 32'hFFFF_FFFF || b_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_hold: got addr=%0d data=%0h wr=%b want 1 ffffffff 0",
               b_addr, b_data, b_wr_en);
    end
  endtask

  task automatic test_no_start();
    logic [7:0] bytes [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    wa_q.delete(); wd_q.delete();
    for (int i = 0; i < 4; i++) begin
      send(0, bytes[i], 1);
      vectors++;
      if (b_stall !== 1'b0) begin
        miscompares++; $display("FAIL nostart_stall%0d: got %b want 0", i, b_stall);
      end
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (wa_q.size() != 0) begin
      miscompares++; $display("FAIL nostart_writes: got %0d want 0", wa_q.size());
    end
  endtask

  task automatic test_restart_ignored();
    bit seen;
    logic [31:0] exp_d [3] = '{32'h0000_0001, 32'hABCD_EF12, 32'hFFFF_FFFF};
    wa_q.delete(); wd_q.delete();
    pulse_start(0);
    send_word(0, 32'h0000_0001, 1, 0);
    send(0, 8'hAB, 1);
    pulse_start(0);
    send(0, 8'hCD, 1);
    send(0, 8'hEF, 1);
    send(0, 8'h12, 1);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    wait_done(0, seen);
    @(negedge clk);
    vectors++;
    if (!seen || b_count !== 11'd3) begin
      miscompares++; $display("FAIL restart_done: got done=%b count=%0d want 1 3", seen, b_count);
    end
    vectors++;
    if (wa_q.size() != 3) begin
      miscompares++; $display("FAIL restart_nwrites: got %0d want 3", wa_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        vectors++;
        if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL restart_w%0d: got %0h@%0d want %0h@%0d", i, wd_q[i], wa_q[i], exp_d[i], i);
        end
      end
    end
  endtask

  task automatic test_reset_mid_load();
    bit seen;
    wa_q.delete(); wd_q.delete();
    pulse_start(0);
    send(0, 8'h12, 1);
    send(0, 8'h34, 1);
    rst = 1'b1;
    #1;
    vectors++;
    if ({b_wr_en, b_stall, b_done, b_ovf} !== 4'b0 || b_addr !== 10'd0 || b_data !== 32'd0) begin
      miscompares++;
      $display("FAIL midrst_out: got flags=%b addr=%0d data=%0h want 0", {b_wr_en, b_stall, b_done,
               b_ovf}, b_addr, b_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (wa_q.size() != 0 || b_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_nowrite: got writes=%0d stall=%b want 0 0", wa_q.size(), b_stall);
    end
    pulse_start(0);
    send_word(0, 32'hDEAD_BEEF, 1, 0);
    send_word(0, 32'hFFFF_FFFF, 1, 1);
    wait_done(0, seen);
    @(negedge clk);
    vectors++;
    if (!seen || wa_q.size() != 2) begin
      miscompares++;
      $display("FAIL midrst_reload: got done=%b writes=%0d want 1 2", seen, wa_q.size());
    end else if (wa_q[0] !== 10'd0 || wd_q[0] !== 32'hDEAD_BEEF || wa_q[1] !== 10'd1) begin
      miscompares++;
      $display("FAIL midrst_data: got %0h@%0d then @%0d want deadbeef@0 then @1",
               wd_q[0], wa_q[0], wa_q[1]);
    end
  endtask

  task automatic test_spacing();
    bit seen;
    int gaps [2] = '{1, 100};
    logic [31:0] exp_d [3] = '{32'hCAFE_F00D, 32'h0BAD_C0DE, 32'hFFFF_FFFF};
    for (int g = 0; g < 2; g++) begin
      wa_q.delete(); wd_q.delete();
      pulse_start(0);
      send_word(0, exp_d[0], gaps[g], 0);
      send_word(0, exp_d[1], gaps[g], 0);
      send_word(0, exp_d[2], gaps[g], 1);
      wait_done(0, seen);
      @(negedge clk);
      vectors++;
      if (!seen || wa_q.size() != 3) begin
        miscompares++;
        $display("FAIL spacing_gap%0d: got done=%b writes=%0d want 1 3", gaps[g], seen, wa_q.size());
      end else begin
        for (int i = 0; i < 3; i++) begin
          vectors++;
          if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_d[i]) begin
            miscompares++;
            $display("FAIL spacing_gap%0d_w%0d: got %0h@%0d want %0h@%0d", gaps[g], i, wd_q[i],
                     wa_q[i], exp_d[i], i);
          end
        end
      end
    end
  endtask

  task automatic test_overflow();
    bit seen;
    logic [31:0] exp_d [4] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'h0102_0304};
    sa_q.delete(); sd_q.delete();
    pulse_start(1);
    for (int i = 0; i < 4; i++) send_word(1, exp_d[i], 1, i == 3);
    wait_done(1, seen);
    vectors++;
    if (!seen || s_stall !== 1'b1 || s_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_done: got done=%b stall=%b ovf=%b want 1 1 1", seen, s_stall, s_ovf);
    end
    @(negedge clk);
    send_word(1, 32'h7777_7777, 1, 0);
    repeat (3) @(negedge clk);
    vectors++;
    if (s_ovf !== 1'b1 || s_count !== 3'd4 || s_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_after: got ovf=%b count=%0d stall=%b want 1 4 0", s_ovf, s_count, s_stall);
    end
    vectors++;
    if (sa_q.size() != 4) begin
      miscompares++; $display("FAIL ovf_nwrites: got %0d want 4", sa_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (sa_q[i] !== 2'(i) || sd_q[i] !== exp_d[i]) begin
          miscompares++;
          $display("FAIL ovf_w%0d: got %0h@%0d want %0h@%0d", i, sd_q[i], sa_q[i], exp_d[i], i);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    b_start   = 1'b0; b_rx_done = 1'b0; b_rx_data = 8'h00;
    s_start   = 1'b0; s_rx_done = 1'b0; s_rx_data = 8'h00;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_no_start();
    test_restart_ignored();
    test_reset_mid_load();
    test_spacing();
    test_overflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
